// File: rtl/alu_issue_arbiter.sv
// rtl/alu_issue_arbiter.sv - round-robin issue arbiter sharing one 2-stage ALU (optional stats: ALU_ARB_STATS_EN)
module alu_issue_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    hold,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0]      req_r_i_s,
    input  logic [3*NUM_REQ-1:0]    req_funct3,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [31:0]             alu_a,
    output logic [31:0]             alu_b,
    output logic                    alu_in_valid,
    output logic                    alu_r_i_s,
    output logic [2:0]              alu_funct3,
    input  logic [31:0]             alu_out,
    input  logic                    alu_out_valid,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [31:0]             rsp_data,
    output logic                    err
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [32*NUM_REQ-1:0]   stat_grants,
    output logic [31:0]             stat_stalls
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] rr_ptr;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_any;
    logic [31:0]        sel_a;
    logic [31:0]        sel_b;
    logic [2:0]         sel_funct3;
    logic               sel_r_i_s;

    // Tag pipeline follows the op through the ALU's two register stages.
    logic               tag0_valid;
    logic [ID_W-1:0]    tag0_id;
    logic               tag1_valid;
    logic [ID_W-1:0]    tag1_id;
    logic               tag2_valid;
    logic [ID_W-1:0]    tag2_id;

    // Control captured at issue; presented to the ALU one cycle later, during its compute cycle.
    logic               ctrl0_r_i_s;
    logic [2:0]         ctrl0_funct3;

    // Nonzero for the first two cycles after reset, hiding results of ops the reset orphaned.
    logic [1:0]         drain_cnt;
    logic               rsp_on;

    // Round-robin search starting at rr_ptr; first valid requester wins unless stalled.
    always_comb begin
        int idx;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(rr_ptr) + off) % NUM_REQ;
            if (!grant_any && !hold && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
        if (grant_any) begin
            grant[grant_id] = 1'b1;
        end
    end

    assign req_ready = grant;

    // Select the granted requester's operands and control.
    always_comb begin
        sel_a      = '0;
        sel_b      = '0;
        sel_funct3 = '0;
        sel_r_i_s  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                sel_a      = req_a[32*k +: 32];
                sel_b      = req_b[32*k +: 32];
                sel_funct3 = req_funct3[3*k +: 3];
                sel_r_i_s  = req_r_i_s[k];
            end
        end
    end

    // Pointer moves just past the accepted requester; holds when nothing is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            if (grant_id == ID_W'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_id + 1'b1;
            end
        end
    end

    // Issue stage: operands, valid, tag and control are captured on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_in_valid <= 1'b0;
            tag0_valid   <= 1'b0;
            tag0_id      <= '0;
            ctrl0_r_i_s  <= 1'b0;
            ctrl0_funct3 <= '0;
        end else begin
            alu_in_valid <= grant_any;
            tag0_valid   <= grant_any;
            if (grant_any) begin
                alu_a        <= sel_a;
                alu_b        <= sel_b;
                tag0_id      <= grant_id;
                ctrl0_r_i_s  <= sel_r_i_s;
                ctrl0_funct3 <= sel_funct3;
            end
        end
    end

    // Tags shadow the ALU stages; control is re-timed to the ALU compute cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag1_valid <= 1'b0;
            tag1_id    <= '0;
            tag2_valid <= 1'b0;
            tag2_id    <= '0;
            alu_r_i_s  <= 1'b0;
            alu_funct3 <= '0;
        end else begin
            tag1_valid <= tag0_valid;
            tag1_id    <= tag0_id;
            tag2_valid <= tag1_valid;
            tag2_id    <= tag1_id;
            alu_r_i_s  <= ctrl0_r_i_s;
            alu_funct3 <= ctrl0_funct3;
        end
    end

    // Post-reset drain window counts down from 2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drain_cnt <= 2'd2;
        end else if (drain_cnt != 2'd0) begin
            drain_cnt <= drain_cnt - 2'd1;
        end
    end

    // A result is delivered only when the ALU and the tag pipeline agree it exists.
    assign rsp_on = alu_out_valid && tag2_valid && (drain_cnt == 2'd0);

    // Route the result one-hot to the requester named by the tag.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (rsp_on) begin
            rsp_valid[tag2_id] = 1'b1;
            rsp_data           = alu_out;
        end
    end

    // Sticky flag for an ALU valid that the tag pipeline does not account for, or vice versa.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((drain_cnt == 2'd0) && (alu_out_valid != tag2_valid)) begin
            err <= 1'b1;
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Per-requester accept counters, saturating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_grants <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (grant[k] && (stat_grants[32*k +: 32] != 32'hFFFF_FFFF)) begin
                    stat_grants[32*k +: 32] <= stat_grants[32*k +: 32] + 32'd1;
                end
            end
        end
    end

    // Cycles with demand but no accept (hold), saturating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_stalls <= '0;
        end else if ((|req_valid) && !grant_any && (stat_stalls != 32'hFFFF_FFFF)) begin
            stat_stalls <= stat_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb/tb_alu_issue_arbiter.sv - directed self-checking bench for alu_issue_arbiter
module tb_alu_issue_arbiter;

    localparam int N = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            hold = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_r_i_s = '0;
    logic [3*N-1:0]  req_funct3 = '0;
    logic [32*N-1:0] req_a = '0;
    logic [32*N-1:0] req_b = '0;
    logic [31:0]     alu_a;
    logic [31:0]     alu_b;
    logic            alu_in_valid;
    logic            alu_r_i_s;
    logic [2:0]      alu_funct3;
    logic [31:0]     alu_out;
    logic            alu_out_valid;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_data;
    logic            err;
`ifdef ALU_ARB_STATS_EN
    logic [32*N-1:0] stat_grants;
    logic [31:0]     stat_stalls;
`endif

    int total = 0;
    int bad = 0;

    logic [31:0] a_r = '0;
    logic [31:0] b_r = '0;
    logic        v_r = 1'b0;
    logic [31:0] out_d = '0;
    logic        out_v = 1'b0;
    logic        force_ov = 1'b0;

    alu_issue_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready), .req_r_i_s(req_r_i_s),
        .req_funct3(req_funct3), .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_in_valid(alu_in_valid),
        .alu_r_i_s(alu_r_i_s), .alu_funct3(alu_funct3),
        .alu_out(alu_out), .alu_out_valid(alu_out_valid),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err)
`ifdef ALU_ARB_STATS_EN
        , .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'b000:  alu_fn = a + b;
            3'b001:  alu_fn = a << b[4:0];
            3'b100:  alu_fn = a ^ b;
            3'b101:  alu_fn = a >> b[4:0];
            3'b110:  alu_fn = a | b;
            3'b111:  alu_fn = a & b;
            default: alu_fn = '0;
        endcase
    endfunction

    // External 2-stage ALU: operands registered, control sampled live in the compute cycle.
    always @(posedge clk) begin
        a_r   <= alu_a;
        b_r   <= alu_b;
        v_r   <= alu_in_valid;
        out_v <= v_r;
        out_d <= alu_fn(alu_funct3, a_r, b_r);
    end

    assign alu_out       = out_d;
    assign alu_out_valid = out_v | force_ov;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int k, input logic ris, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        req_r_i_s[k]        = ris;
        req_funct3[3*k +: 3] = f;
        req_a[32*k +: 32]   = a;
        req_b[32*k +: 32]   = b;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        hold      = 1'b0;
        force_ov  = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        // Test 1: single op, reset state, latency
        do_reset();
        #1;
        check("rst_in_valid", alu_in_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_funct3", alu_funct3, 0);
        check("rst_r_i_s", alu_r_i_s, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_err", err, 0);
        check("rst_ready", req_ready, 0);
        set_op(0, 1'b1, 3'b000, 32'd5, 32'd7);
        req_valid = 2'b01;
        #1;
        check("t1_ready", req_ready, 2'b01);
        cyc();
        req_valid = 2'b00;
        #1;
        check("t1_alu_a", alu_a, 5);
        check("t1_alu_b", alu_b, 7);
        check("t1_in_valid", alu_in_valid, 1);
        check("t1_ris_lag", alu_r_i_s, 0);
        check("t1_rsp_early", rsp_valid, 0);
        cyc();
        #1;
        check("t1_ris", alu_r_i_s, 1);
        check("t1_in_valid_off", alu_in_valid, 0);
        cyc();
        #1;
        check("t1_rsp_valid", rsp_valid, 2'b01);
        check("t1_rsp_data", rsp_data, 12);
        cyc();
        #1;
        check("t1_rsp_done", rsp_valid, 0);

        // Test 2: two requesters continuously, rotation and ordering
        do_reset();
        set_op(0, 1'b1, 3'b111, 32'hF0, 32'h3C);
        set_op(1, 1'b1, 3'b111, 32'h0F, 32'hFF);
        for (int i = 0; i < 8; i++) begin
            req_valid = (i < 4) ? 2'b11 : 2'b00;
            #1;
            check($sformatf("t2_ready%0d", i), req_ready, (i < 4) ? ((i % 2 == 1) ? 2'b10 : 2'b01) : 2'b00);
            if (i >= 3 && i < 7) begin
                check($sformatf("t2_rspv%0d", i), rsp_valid, ((i - 3) % 2 == 1) ? 2'b10 : 2'b01);
                check($sformatf("t2_rspd%0d", i), rsp_data, ((i - 3) % 2 == 1) ? 32'h0F : 32'h30);
            end else begin
                check($sformatf("t2_rspv%0d", i), rsp_valid, 0);
            end
            if (i == 1) begin
                check("t2_a1", alu_a, 32'hF0);
                check("t2_f3_lag", alu_funct3, 0);
            end
            if (i == 2) begin
                check("t2_a2", alu_a, 32'h0F);
                check("t2_f3", alu_funct3, 3'b111);
            end
            cyc();
        end

        // Test 3: back-to-back from req1 with changing control
        do_reset();
        for (int i = 0; i < 7; i++) begin
            req_valid = (i < 3) ? 2'b10 : 2'b00;
            if (i == 0) set_op(1, 1'b1, 3'b001, 32'd1, 32'd4);
            if (i == 1) set_op(1, 1'b1, 3'b101, 32'h80, 32'd3);
            if (i == 2) set_op(1, 1'b0, 3'b000, 32'd2, 32'd2);
            #1;
            check($sformatf("t3_ready%0d", i), req_ready, (i < 3) ? 2'b10 : 2'b00);
            if (i == 3) check("t3_ris3", alu_r_i_s, 1);
            if (i == 4) check("t3_ris4", alu_r_i_s, 0);
            if (i >= 3 && i < 6) begin
                check($sformatf("t3_rspv%0d", i), rsp_valid, 2'b10);
                check($sformatf("t3_rspd%0d", i), rsp_data, (i == 5) ? 32'd4 : 32'd16);
            end else begin
                check($sformatf("t3_rspv%0d", i), rsp_valid, 0);
            end
            cyc();
        end

        // Test 4: hold stalls issue, in-flight op drains, rotation resumes
        do_reset();
        set_op(0, 1'b0, 3'b000, 32'd5, 32'd7);
        set_op(1, 1'b0, 3'b000, 32'd1, 32'd1);
        for (int i = 0; i < 9; i++) begin
            hold      = (i >= 1 && i <= 4);
            req_valid = (i <= 5) ? 2'b11 : 2'b00;
            #1;
            check($sformatf("t4_ready%0d", i), req_ready,
                  (i == 0) ? 2'b01 : ((i == 5) ? 2'b10 : 2'b00));
            if (i == 3) begin
                check("t4_rspv3", rsp_valid, 2'b01);
                check("t4_rspd3", rsp_data, 12);
            end else if (i == 8) begin
                check("t4_rspv8", rsp_valid, 2'b10);
                check("t4_rspd8", rsp_data, 2);
            end else begin
                check($sformatf("t4_rspv%0d", i), rsp_valid, 0);
            end
            cyc();
        end
        hold = 1'b0;

        // Test 5: reset mid-flight, then a stray ALU valid sets sticky err
        do_reset();
        set_op(0, 1'b0, 3'b000, 32'd5, 32'd7);
        req_valid = 2'b01;
        #1;
        check("t5_ready", req_ready, 2'b01);
        cyc();
        req_valid = 2'b00;
        rst_n     = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("t5_rspv%0d", i), rsp_valid, 0);
            check($sformatf("t5_err%0d", i), err, 0);
            cyc();
        end
        force_ov = 1'b1;
        #1;
        check("t5_force_rspv", rsp_valid, 0);
        cyc();
        force_ov = 1'b0;
        #1;
        check("t5_err_set", err, 1);
        cyc();
        cyc();
        check("t5_err_sticky", err, 1);

`ifdef ALU_ARB_STATS_EN
        // Test 6: statistics counters
        do_reset();
        set_op(0, 1'b0, 3'b000, 32'd1, 32'd1);
        set_op(1, 1'b0, 3'b000, 32'd2, 32'd2);
        req_valid = 2'b01;
        for (int i = 0; i < 10; i++) cyc();
        req_valid = 2'b10;
        for (int i = 0; i < 3; i++) cyc();
        req_valid = 2'b01;
        hold      = 1'b1;
        for (int i = 0; i < 2; i++) cyc();
        req_valid = 2'b00;
        hold      = 1'b0;
        cyc();
        check("t6_grants0", stat_grants[31:0], 10);
        check("t6_grants1", stat_grants[63:32], 3);
        check("t6_stalls", stat_stalls, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
